// File: rtl/sm_cpu_param_if.sv
// Handshake and result bus of the sm_cpu_param core.
// The master drives load/start/instr; the core reports waiting, the C register, flags and illegal.
interface sm_cpu_param_if #(
    parameter int DATA_W = 16
);
    logic              load;
    logic              start;
    logic [15:0]       instr;
    logic              waiting;
    logic [DATA_W-1:0] out;
    logic              N;
    logic              V;
    logic              Z;
    logic              illegal;

    modport master (
        output load, start, instr,
        input  waiting, out, N, V, Z, illegal
    );

    modport slave (
        input  load, start, instr,
        output waiting, out, N, V, Z, illegal
    );
endinterface

// File: rtl/sm_cpu_param.sv
// Multi-cycle Simple RISC Machine core: 8 x DATA_W register file, shifter, ALU, N/V/Z flags.
// Latency 1-5 edges after start; load/start are only accepted while waiting=1, otherwise ignored.
module sm_cpu_param #(
    parameter int DATA_W       = 16,
    parameter bit FLAGS_ON_ALL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    sm_cpu_param_if.slave  bus
);

    localparam int MSB = DATA_W - 1;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [1:0] SUB_IMM = 2'b10;
    localparam logic [1:0] SUB_REG = 2'b00;
    localparam logic [1:0] SUB_ADD = 2'b00;
    localparam logic [1:0] SUB_CMP = 2'b01;
    localparam logic [1:0] SUB_AND = 2'b10;
    localparam logic [1:0] SUB_MVN = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_C
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic              n_q, n_d;
    logic              v_q, v_d;
    logic              z_q, z_d;
    logic              illegal_q, illegal_d;

    logic [2:0]        op, rn, rd, rm;
    logic [1:0]        sub, sh;
    logic [7:0]        imm8;
    logic [DATA_W-1:0] imm_ext;

    assign op   = ir_q[15:13];
    assign sub  = ir_q[12:11];
    assign rn   = ir_q[10:8];
    assign rd   = ir_q[7:5];
    assign sh   = ir_q[4:3];
    assign rm   = ir_q[2:0];
    assign imm8 = ir_q[7:0];

    assign imm_ext = DATA_W'($signed(imm8));

    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign is_mov_imm = (op == OP_MOV) && (sub == SUB_IMM);
    assign is_mov_reg = (op == OP_MOV) && (sub == SUB_REG);
    assign is_alu     = (op == OP_ALU);
    assign is_cmp     = is_alu && (sub == SUB_CMP);
    assign is_mvn     = is_alu && (sub == SUB_MVN);

    // Shifter sits on the B operand only; A always enters the ALU unshifted.
    logic [DATA_W-1:0] b_sh, sum, diff, alu_res;
    logic              add_ovf, sub_ovf, alu_v;

    always_comb begin
        b_sh = b_q;
        case (sh)
            2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[MSB:1]};
            2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
            default: b_sh = b_q;
        endcase
    end

    assign sum     = a_q + b_sh;
    assign diff    = a_q - b_sh;
    assign add_ovf = (a_q[MSB] == b_sh[MSB]) && (sum[MSB] != a_q[MSB]);
    assign sub_ovf = (a_q[MSB] != b_sh[MSB]) && (diff[MSB] != a_q[MSB]);

    always_comb begin
        alu_res = b_sh;
        alu_v   = 1'b0;
        if (is_alu) begin
            case (sub)
                SUB_ADD: begin alu_res = sum;  alu_v = add_ovf; end
                SUB_CMP: begin alu_res = diff; alu_v = sub_ovf; end
                SUB_AND: alu_res = a_q & b_sh;
                default: alu_res = ~b_sh;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        regs_d    = regs_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        n_d       = n_q;
        v_d       = v_q;
        z_d       = z_q;
        illegal_d = illegal_q;

        case (state_q)
            S_WAIT: begin
                if (bus.load) begin
                    ir_d = bus.instr;
                end
                if (bus.start) begin
                    state_d   = S_DECODE;
                    illegal_d = 1'b0;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = S_GET_B;
                end else if (is_alu) begin
                    state_d = S_GET_A;
                end else begin
                    state_d   = S_WAIT;
                    illegal_d = 1'b1;
                end
            end
            S_WRITE_IMM: begin
                regs_d[rn] = imm_ext;
                state_d    = S_WAIT;
            end
            S_GET_A: begin
                a_d     = regs_q[rn];
                state_d = S_GET_B;
            end
            S_GET_B: begin
                b_d     = regs_q[rm];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                c_d = alu_res;
                if (is_cmp || FLAGS_ON_ALL) begin
                    z_d = (alu_res == '0);
                    n_d = alu_res[MSB];
                    v_d = alu_v;
                end
                // CMP has no destination, so it skips the write-back state.
                state_d = is_cmp ? S_WAIT : S_WRITE_C;
            end
            S_WRITE_C: begin
                regs_d[rd] = c_q;
                state_d    = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            z_q       <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            n_q       <= n_d;
            v_q       <= v_d;
            z_q       <= z_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign bus.waiting = (state_q == S_WAIT);
    assign bus.out     = c_q;
    assign bus.N       = n_q;
    assign bus.V       = v_q;
    assign bus.Z       = z_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_sm_cpu_param.sv
// Bench for sm_cpu_param: a 16-bit (flags on CMP only) and a 32-bit (flags on all ops) core,
// each compared against an arithmetic reference model under directed and random programs.
module tb_sm_cpu_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm_cpu_param_if #(.DATA_W(16)) bus16 ();
    sm_cpu_param_if #(.DATA_W(32)) bus32 ();

    sm_cpu_param #(.DATA_W(16), .FLAGS_ON_ALL(1'b0)) u_cpu16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    sm_cpu_param #(.DATA_W(32), .FLAGS_ON_ALL(1'b1)) u_cpu32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_reg [2][8];
    logic [63:0] m_out [2];
    bit          m_n [2];
    bit          m_v [2];
    bit          m_z [2];
    bit          m_ill [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [15:0] ins);
        return (ins[15:13] == 3'b101) ||
               (ins[15:13] == 3'b110 && (ins[12:11] == 2'b00 || ins[12:11] == 2'b10));
    endfunction

    function automatic longint to_s(input logic [63:0] x, input int w);
        if (x[w-1]) return longint'(x) - (longint'(1) << w);
        return longint'(x);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_reg[d][i] = '0;
            m_out[d] = '0;
            m_n[d] = 0; m_v[d] = 0; m_z[d] = 0; m_ill[d] = 0;
        end
    endtask

    task automatic set_flags(input int d, input logic [63:0] res, input logic [63:0] msb, input bit v);
        m_z[d] = (res == 64'd0);
        m_n[d] = ((res & msb) != 64'd0);
        m_v[d] = v;
    endtask

    task automatic model_exec(input int d, input logic [15:0] ins, output int lat);
        int          w;
        bit          fa;
        logic [63:0] mask, msb, a, b, res;
        logic [2:0]  op, rn, rd, rm;
        logic [1:0]  sub, sh;
        longint      sa, sb, sr, lim;
        w    = (d == 0) ? 16 : 32;
        fa   = (d == 1);
        mask = (64'd1 << w) - 64'd1;
        msb  = 64'd1 << (w - 1);
        lim  = longint'(1) << (w - 1);
        op = ins[15:13]; sub = ins[12:11]; rn = ins[10:8];
        rd = ins[7:5];   sh = ins[4:3];    rm = ins[2:0];
        a = m_reg[d][rn];
        b = m_reg[d][rm];
        case (sh)
            2'd1:    b = (b << 1) & mask;
            2'd2:    b = b >> 1;
            2'd3:    b = (b >> 1) | (b & msb);
            default: ;
        endcase
        sa = to_s(a, w);
        sb = to_s(b, w);
        lat = 0;
        if (!is_legal(ins)) begin
            m_ill[d] = 1;
            lat = 1;
        end else begin
            m_ill[d] = 0;
            if (op == 3'b110 && sub == 2'b10) begin
                m_reg[d][rn] = ins[7] ? ((mask & ~64'hFF) | {56'd0, ins[7:0]}) : {56'd0, ins[7:0]};
                lat = 2;
            end else if (op == 3'b110) begin
                res = b; m_out[d] = res; m_reg[d][rd] = res;
                if (fa) set_flags(d, res, msb, 0);
                lat = 4;
            end else begin
                case (sub)
                    2'b00: begin
                        res = (a + b) & mask; sr = sa + sb;
                        m_out[d] = res; m_reg[d][rd] = res;
                        if (fa) set_flags(d, res, msb, (sr >= lim) || (sr < -lim));
                        lat = 5;
                    end
                    2'b01: begin
                        res = (a - b) & mask; sr = sa - sb;
                        m_out[d] = res;
                        set_flags(d, res, msb, (sr >= lim) || (sr < -lim));
                        lat = 4;
                    end
                    2'b10: begin
                        res = a & b; m_out[d] = res; m_reg[d][rd] = res;
                        if (fa) set_flags(d, res, msb, 0);
                        lat = 5;
                    end
                    default: begin
                        res = ~b & mask; m_out[d] = res; m_reg[d][rd] = res;
                        if (fa) set_flags(d, res, msb, 0);
                        lat = 4;
                    end
                endcase
            end
        end
    endtask

    // ---------------- DUT access ----------------
    task automatic drive(input int d, input logic ld, input logic st, input logic [15:0] ins);
        if (d == 0) begin bus16.load = ld; bus16.start = st; bus16.instr = ins; end
        else        begin bus32.load = ld; bus32.start = st; bus32.instr = ins; end
    endtask

    function automatic logic [63:0] obs_out(input int d);
        return (d == 0) ? {48'd0, bus16.out} : {32'd0, bus32.out};
    endfunction

    function automatic logic [2:0] obs_flags(input int d);
        return (d == 0) ? {bus16.Z, bus16.V, bus16.N} : {bus32.Z, bus32.V, bus32.N};
    endfunction

    function automatic logic obs_wait(input int d);
        return (d == 0) ? bus16.waiting : bus32.waiting;
    endfunction

    function automatic logic obs_ill(input int d);
        return (d == 0) ? bus16.illegal : bus32.illegal;
    endfunction

    task automatic check_state(input int d, input string tag);
        check_eq({tag, " out"}, obs_out(d), m_out[d]);
        check_eq({tag, " ZVN"}, {61'd0, obs_flags(d)}, {61'd0, m_z[d], m_v[d], m_n[d]});
        check_eq({tag, " illegal"}, {63'd0, obs_ill(d)}, {63'd0, m_ill[d]});
    endtask

    // Start one instruction; without use_load the IR must already hold ins and the bus carries ~ins.
    task automatic run(input int d, input logic [15:0] ins, input bit use_load, input bit disturb);
        int exp_lat;
        int cnt;
        bit done;
        model_exec(d, ins, exp_lat);
        @(negedge clk);
        drive(d, use_load, 1'b1, use_load ? ins : ~ins);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, ins);
        check_eq("busy after e0", {63'd0, obs_wait(d)}, 64'd0);
        cnt  = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            cnt++;
            if (disturb && cnt == 1) drive(d, 1'b1, 1'b1, 16'($urandom));
            if (disturb && cnt == 2) drive(d, 1'b0, 1'b0, ins);
            if (obs_wait(d)) done = 1;
        end
        check_eq("latency", 64'(cnt), 64'(exp_lat));
        check_state(d, "exec");
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] ins;
        logic [10:0] r11;
        r11 = 11'($urandom);
        case ($urandom_range(0, 6))
            0: ins = {3'b110, 2'b10, r11};
            1: ins = {3'b110, 2'b00, r11};
            2: ins = {3'b101, 2'b00, r11};
            3: ins = {3'b101, 2'b01, r11};
            4: ins = {3'b101, 2'b10, r11};
            5: ins = {3'b101, 2'b11, r11};
            default: begin
                ins = 16'($urandom);
                while (is_legal(ins)) ins = 16'($urandom);
            end
        endcase
        return ins;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins;
        int          d;
        model_reset();
        drive(0, 0, 0, 16'h0);
        drive(1, 0, 0, 16'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq("reset waiting", {63'd0, obs_wait(k)}, 64'd1);
            check_state(k, "reset");
        end
        rst_n = 1'b1;

        // MOV R0..R7,#1..#8, then MOV R2,R6
        for (int i = 0; i < 8; i++) run(0, 16'(16'hD000 | (i << 8) | (i + 1)), 1, 0);
        run(0, 16'hC046, 1, 0);
        check_eq("mov reg out", obs_out(0), 64'd7);
        check_eq("mov reg flags", {61'd0, obs_flags(0)}, 64'd0);

        run(0, 16'hA2E6, 1, 0);
        check_eq("add out", obs_out(0), 64'd14);
        run(0, 16'hA2F6, 1, 0);
        check_eq("add lsr out", obs_out(0), 64'd10);
        check_eq("add flags held", {61'd0, obs_flags(0)}, 64'd0);

        // R0=7FFF, R1=8000, CMP R0,R1; then R0=R1=3
        run(0, 16'hD0FF, 1, 0);
        run(0, 16'hC010, 1, 0);
        run(0, 16'hB820, 1, 0);
        run(0, 16'hA801, 1, 0);
        check_eq("cmp ovf V", {63'd0, bus16.V}, 64'd1);
        run(0, 16'hD003, 1, 0);
        run(0, 16'hD103, 1, 0);
        run(0, 16'hA801, 1, 0);
        check_eq("cmp eq out", obs_out(0), 64'd0);
        check_eq("cmp eq flags", {61'd0, obs_flags(0)}, 64'b100);

        run(0, 16'hD405, 1, 0);
        run(0, 16'hB8E4, 1, 0);
        check_eq("mvn out", obs_out(0), 64'hFFFA);
        run(0, 16'hD0FF, 1, 0);
        run(0, 16'hC018, 1, 0);
        check_eq("asr -1 out", obs_out(0), 64'hFFFF);

        run(0, 16'hE000, 1, 0);
        check_eq("illegal set", {63'd0, obs_ill(0)}, 64'd1);
        run(0, 16'hA2E6, 1, 1);

        // load without start: held in WAIT, then start alone executes the captured word
        @(negedge clk); drive(0, 1'b1, 1'b0, 16'hA0E2);
        @(negedge clk); drive(0, 1'b0, 1'b0, 16'h5A5A);
        repeat (3) @(negedge clk);
        check_eq("hold waiting", {63'd0, obs_wait(0)}, 64'd1);
        check_state(0, "hold");
        run(0, 16'hA0E2, 0, 0);

        // reset after e2 of an ADD
        @(negedge clk); drive(0, 1'b1, 1'b1, 16'hA2E6);
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, 16'h0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check_eq("midreset waiting", {63'd0, obs_wait(k)}, 64'd1);
            check_state(k, "midreset");
        end
        @(negedge clk); rst_n = 1'b1;
        run(0, 16'hC0E7, 1, 0);
        check_eq("regs cleared", obs_out(0), 64'd0);

        // 32-bit, flags on all ops
        run(1, 16'hD180, 1, 0);
        run(1, 16'hA141, 1, 0);
        check_eq("w32 add out", obs_out(1), 64'hFFFFFF00);
        check_eq("w32 add flags", {61'd0, obs_flags(1)}, 64'b001);

        for (int it = 0; it < 500; it++) begin
            d   = $urandom_range(0, 1);
            ins = rand_instr();
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); drive(d, 1'b1, 1'b0, ins);
                @(negedge clk); drive(d, 1'b0, 1'b0, ~ins);
                run(d, ins, 0, 0);
            end else begin
                run(d, ins, 1, 0);
            end
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
